// File: rtl/cvt_itof_pipe.sv
// Pipelined signed 32-bit integer to IEEE-754 single-precision converter with valid/ready on both sides.
// Define ITOF_INEXACT_FLAG_EN to add the out_inexact output (guard or sticky bits were nonzero).

module cvt_itof_pipe #(
   parameter int ROUND_NEAREST = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
`ifdef ITOF_INEXACT_FLAG_EN
   ,output logic       out_inexact
`endif
);

   logic        adv;

   logic        s1_valid_q, s1_sign_q, s1_zero_q;
   logic [31:0] s1_mag_q, s1_mag_d;

   logic        s2_valid_q, s2_sign_q, s2_zero_q;
   logic [4:0]  s2_lz_q, s2_lz_d;
   logic [30:0] s2_norm_q, s2_norm_d;

   logic        s3_valid_q;
   logic [31:0] s3_data_q, s3_data_d;

   logic        out_valid_q;
   logic [31:0] out_data_q;

   logic [22:0] mant;
   logic [23:0] mant_sum;
   logic [7:0]  exp_base, exp_rnd;
   logic        guard_bit, sticky_bit, inc;

   // The whole pipeline moves as one; a stalled consumer freezes every stage.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // Two's-complement negate; 0x80000000 maps onto itself, which is its correct magnitude.
   assign s1_mag_d = in_data[31] ? (~in_data + 32'd1) : in_data;

   // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      s2_lz_d = 5'd31;
      for (int i = 0; i < 32; i++) begin
         if (s1_mag_q[i]) s2_lz_d = 5'(31 - i);
      end
      s2_norm_d = 31'(s1_mag_q << s2_lz_d);
   end

   always_comb begin
      mant       = s2_norm_q[30:8];
      guard_bit  = s2_norm_q[7];
      sticky_bit = |s2_norm_q[6:0];
      exp_base   = 8'd158 - {3'b000, s2_lz_q};
      inc        = (ROUND_NEAREST != 0) && guard_bit && (sticky_bit || mant[0]);
      mant_sum   = {1'b0, mant} + {23'd0, inc};
      exp_rnd    = mant_sum[23] ? exp_base + 8'd1 : exp_base;
      // A zero input packs to +0, never -0.
      s3_data_d  = s2_zero_q ? 32'd0 : {s2_sign_q, exp_rnd, mant_sum[22:0]};
   end

`ifdef ITOF_INEXACT_FLAG_EN
   logic s3_inexact_q, out_inexact_q;
`endif

   // NOTE: sequential state is assigned with <= only, so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_mag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_lz_q     <= '0;
         s2_norm_q   <= '0;
         s3_valid_q  <= 1'b0;
         s3_data_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef ITOF_INEXACT_FLAG_EN
         s3_inexact_q  <= 1'b0;
         out_inexact_q <= 1'b0;
`endif
      end else if (adv) begin
         s1_valid_q  <= in_valid;
         s1_sign_q   <= in_data[31];
         s1_zero_q   <= (in_data == 32'd0);
         s1_mag_q    <= s1_mag_d;
         s2_valid_q  <= s1_valid_q;
         s2_sign_q   <= s1_sign_q;
         s2_zero_q   <= s1_zero_q;
         s2_lz_q     <= s2_lz_d;
         s2_norm_q   <= s2_norm_d;
         s3_valid_q  <= s2_valid_q;
         s3_data_q   <= s3_data_d;
         out_valid_q <= s3_valid_q;
         out_data_q  <= s3_data_q;
`ifdef ITOF_INEXACT_FLAG_EN
         s3_inexact_q  <= guard_bit || sticky_bit;
         out_inexact_q <= s3_inexact_q;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
`ifdef ITOF_INEXACT_FLAG_EN
   assign out_inexact = out_inexact_q;
`endif

endmodule

// File: tb/tb_cvt_itof_pipe.sv
// Directed bench for cvt_itof_pipe: latency, rounding, ties, backpressure, mid-flight reset, random stream.
// Build with ITOF_INEXACT_FLAG_EN defined to also exercise out_inexact.

module tb_cvt_itof_pipe;

   localparam int ROUND_NEAREST = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
`ifdef ITOF_INEXACT_FLAG_EN
   logic        out_inexact;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   cvt_itof_pipe #(.ROUND_NEAREST(ROUND_NEAREST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef ITOF_INEXACT_FLAG_EN
      ,.out_inexact (out_inexact)
`endif
   );

   // Every output transfer is logged; inputs only change just after the rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference conversion by explicit quotient/remainder rounding; returns {inexact, float}.
   function automatic logic [32:0] ref_itof(input logic [31:0] x);
      logic [63:0] m, q, rem, half;
      int          e, sh;
      logic        s, inexact;
      if (x == 32'd0) return 33'd0;
      s = x[31];
      m = s ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
      e = 0;
      for (int i = 0; i < 64; i++) if (m[i]) e = i;
      inexact = 1'b0;
      if (e <= 23) begin
         q = m << (23 - e);
      end else begin
         sh      = e - 23;
         q       = m >> sh;
         rem     = m & ((64'd1 << sh) - 64'd1);
         half    = 64'd1 << (sh - 1);
         inexact = (rem != 64'd0);
         if (ROUND_NEAREST != 0 && (rem > half || (rem == half && q[0]))) q = q + 64'd1;
         if (q[24]) begin
            q = q >> 1;
            e++;
         end
      end
      return {inexact, s, 8'(127 + e), q[22:0]};
   endfunction

   task automatic convert(input string tag, input logic [31:0] x, input logic [31:0] expv,
                          input logic exp_inexact);
      int n;
      in_valid  = 1'b1;
      in_data   = x;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check(tag, out_data, expv);
`ifdef ITOF_INEXACT_FLAG_EN
      check({tag, "_inexact"}, 32'(out_inexact), 32'(exp_inexact));
`else
      if (exp_inexact === 1'bx) $display("note: unknown inexact expectation for %s", tag);
`endif
      step();
   endtask

   logic [31:0] bp_v[5]   = '{32'd7, 32'hFFFF_FF9C, 32'd1000000, 32'h0100_0001, 32'd255};
   logic [31:0] bp_exp[5] = '{32'h40E0_0000, 32'hC2C8_0000, 32'h4974_2400, 32'h4B80_0000, 32'h437F_0000};

   initial begin
      int          idx;
      logic        acc;
      logic [31:0] stall_data, tmp;
      logic [32:0] r;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      step();
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // 1, -1, 0 back to back: first result visible after the third edge following the accept
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'd1;
      step();
      check("lat_e0_valid", 32'(out_valid), 32'd0);
      in_data = 32'hFFFF_FFFF;
      step();
      check("lat_e1_valid", 32'(out_valid), 32'd0);
      in_data = 32'd0;
      step();
      check("lat_e2_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      step();
      check("lat_e3_valid", 32'(out_valid), 32'd1);
      check("one", out_data, 32'h3F80_0000);
      step();
      check("minus_one_valid", 32'(out_valid), 32'd1);
      check("minus_one", out_data, 32'hBF80_0000);
      step();
      check("zero_valid", 32'(out_valid), 32'd1);
      check("zero", out_data, 32'h0000_0000);
      step();
      check("drained_valid", 32'(out_valid), 32'd0);

      // Single conversions and rounding corners
      convert("v12345", 32'd12345, 32'h4640_E400, 1'b0);
      convert("int_min", 32'h8000_0000, 32'hCF00_0000, 1'b0);
      convert("int_max", 32'h7FFF_FFFF, ROUND_NEAREST != 0 ? 32'h4F00_0000 : 32'h4EFF_FFFF, 1'b1);
      convert("tie_down", 32'd16777217, 32'h4B80_0000, 1'b1);
      convert("tie_up", 32'd16777219, ROUND_NEAREST != 0 ? 32'h4B80_0002 : 32'h4B80_0001, 1'b1);
      convert("exact_2p24", 32'd16777216, 32'h4B80_0000, 1'b0);

      // Backpressure: consumer stalls for 4 cycles while a fifth input waits
      got_q.delete();
      idx = 0;
      stall_data = '0;
      for (int c = 0; c < 60 && got_q.size() < 5; c++) begin
         in_valid  = (idx < 5);
         in_data   = (idx < 5) ? bp_v[idx] : 32'd0;
         out_ready = !(c >= 4 && c < 8);
         #1;
         if (c == 4) stall_data = out_data;
         if (!out_ready) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_data_hold", out_data, stall_data);
         end
         acc = in_valid && in_ready;
         step();
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) step();
      check("bp_count", 32'(got_q.size()), 32'd5);
      for (int i = 0; i < 5 && i < got_q.size(); i++) check("bp_order", got_q[i], bp_exp[i]);

      // Reset with two conversions in flight flushes both
      got_q.delete();
      in_valid = 1'b1;
      in_data  = 32'd5;
      step();
      in_data = 32'd9;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", out_data, 32'd0);
      step();
      rst_n = 1'b1;
      repeat (8) step();
      check("flush_count", 32'(got_q.size()), 32'd0);
      convert("post_rst", 32'd3, 32'h4040_0000, 1'b0);

      // Random stream with random valid/ready against the reference model
      got_q.delete();
      exp_q.delete();
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 3))
            0: tmp = $urandom();
            1: tmp = $urandom() >> $urandom_range(0, 31);
            2: tmp = 32'd0 - ($urandom() >> $urandom_range(0, 31));
            default: tmp = 32'h0100_0000 + 32'($urandom_range(0, 7));
         endcase
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = tmp;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) begin
            r = ref_itof(in_data);
            exp_q.push_back(r[31:0]);
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 20 && got_q.size() < exp_q.size(); n++) step();
      repeat (4) step();
      check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("rand_data", got_q[i], exp_q[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
